// File: rtl/color_mapper_pipe.sv
// Two-stage pixel colour mapper: direct or palette colour, global fade, blanking.
// Ports: Clk/Reset_n, pixel in (valid/mode/color/idx/blank/XY), palette write, fade ctrl, VGA out.
module color_mapper_pipe #(
  parameter int CH_W      = 8,
  parameter int IDX_W     = 4,
  parameter int BR_W      = 5,
  parameter int FADE_STEP = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_valid_in,
  input  logic              mode_in,
  input  logic [3*CH_W-1:0] color_in,
  input  logic [IDX_W-1:0]  pal_idx_in,
  input  logic              blank_n_in,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_waddr,
  input  logic [3*CH_W-1:0] pal_wdata,
  input  logic              fade_start,
  input  logic              fade_dir,
  input  logic              frame_tick,
  output logic [CH_W-1:0]   VGA_R,
  output logic [CH_W-1:0]   VGA_G,
  output logic [CH_W-1:0]   VGA_B,
  output logic              pix_valid_out,
  output logic [9:0]        DrawX_o,
  output logic [9:0]        DrawY_o,
  output logic              fade_busy
);

  localparam logic [BR_W:0] FULL =
    (BR_W+1)'(2**BR_W);
  localparam logic [BR_W:0] STEP =
    (BR_W+1)'(FADE_STEP);

  typedef struct packed {
    logic              valid;
    logic              blank_n;
    logic              mode;
    logic [3*CH_W-1:0] color;
    logic [9:0]        x;
    logic [9:0]        y;
  } s1_t;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    FADE_IN
  } fade_st_t;

  s1_t               s1_q, s1_d;
  logic [3*CH_W-1:0] pal_mem [2**IDX_W];
  logic [3*CH_W-1:0] pal_rd_q;

  logic [3*CH_W-1:0] src_c;
  logic [3*CH_W-1:0] rgb_d, rgb_q;
  logic              vld_q;
  logic [9:0]        x_q, y_q;

  fade_st_t          st_q;
  logic [BR_W:0]     bright_q;
  logic              busy_q;
  logic [BR_W:0]     br_dn, br_up;
  logic [BR_W+1:0]   br_sum;

  // Stage 1: input capture
  always_comb begin
    s1_d         = '0;
    s1_d.valid   = pix_valid_in;
    s1_d.blank_n = blank_n_in;
    s1_d.mode    = mode_in;
    s1_d.color   = color_in;
    s1_d.x       = DrawX;
    s1_d.y       = DrawY;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) s1_q <= '0;
    else          s1_q <= s1_d;
  end

  // Palette: not reset; nonblocking write gives
  // read-before-write on an address collision.
  always_ff @(posedge Clk) begin
    if (pal_we) pal_mem[pal_waddr] <= pal_wdata;
    pal_rd_q <= pal_mem[pal_idx_in];
  end

  // Stage 2: select, scale, mask
  function automatic logic [CH_W-1:0] scale(
    input logic [CH_W-1:0] c,
    input logic [BR_W:0]   b
  );
    logic [CH_W+BR_W:0] p;
    p = {{(BR_W+1){1'b0}}, c} * {{CH_W{1'b0}}, b};
    return CH_W'(p >> BR_W);
  endfunction

  always_comb begin
    src_c = s1_q.mode ? pal_rd_q : s1_q.color;
    rgb_d = '0;
    if (s1_q.valid && s1_q.blank_n) begin
      rgb_d = {scale(src_c[3*CH_W-1 -: CH_W], bright_q),
               scale(src_c[2*CH_W-1 -: CH_W], bright_q),
               scale(src_c[CH_W-1:0], bright_q)};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q <= '0;
      vld_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      rgb_q <= rgb_d;
      vld_q <= s1_q.valid;
      x_q   <= s1_q.x;
      y_q   <= s1_q.y;
    end
  end

  assign VGA_R         = rgb_q[3*CH_W-1 -: CH_W];
  assign VGA_G         = rgb_q[2*CH_W-1 -: CH_W];
  assign VGA_B         = rgb_q[CH_W-1:0];
  assign pix_valid_out = vld_q;
  assign DrawX_o       = x_q;
  assign DrawY_o       = y_q;

  // Saturating brightness steps
  always_comb begin
    br_dn  = (bright_q > STEP) ? bright_q - STEP : '0;
    br_sum = {1'b0, bright_q} + {1'b0, STEP};
    br_up  = (br_sum >= {1'b0, FULL}) ?
             FULL : br_sum[BR_W:0];
  end

  // Fade FSM; start is only honoured in IDLE,
  // so a start+tick in IDLE never steps.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st_q     <= IDLE;
      bright_q <= FULL;
      busy_q   <= 1'b0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (fade_start) begin
            st_q   <= fade_dir ? FADE_IN : FADE_OUT;
            busy_q <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (frame_tick) begin
            bright_q <= br_dn;
            if (br_dn == '0) begin
              st_q   <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        FADE_IN: begin
          if (frame_tick) begin
            bright_q <= br_up;
            if (br_up == FULL) begin
              st_q   <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          st_q   <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign fade_busy = busy_q;

endmodule
